// File: rtl/calc_regfile_alu.sv
// Register-file calculator: NREG operand registers feeding a 2-bit-opcode ALU
// whose registered result can be fed back as operand A (accumulate mode).
module calc_regfile_alu #(
   parameter int WIDTH = 8,
   parameter int NREG  = 4,
   localparam int SEL_W = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_en,
   input  logic [SEL_W-1:0] load_sel,
   input  logic [WIDTH-1:0] din,
   input  logic             exec_en,
   input  logic [1:0]       op,
   input  logic [SEL_W-1:0] sel_a,
   input  logic [SEL_W-1:0] sel_b,
   input  logic             acc_mode,
   input  logic [SEL_W-1:0] rd_sel,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             valid
);

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_XOR = 2'b11
   } alu_op_t;

   logic [WIDTH-1:0] regs_reg [NREG];
   logic [NREG-1:0]  wr_dec;

   logic [WIDTH-1:0] result_reg, result_next;
   logic             carry_reg, carry_next;
   logic             overflow_reg, overflow_next;
   logic             zero_reg, zero_next;
   logic             valid_reg;

   logic [WIDTH-1:0] op_a, op_b;
   logic [WIDTH:0]   sum_ext, diff_ext;
   alu_op_t          alu_op;

   // One write strobe per register so the file update is a plain enable per entry.
   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_wr_dec
         assign wr_dec[gi] = load_en && (load_sel == SEL_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int i = 0; i < NREG; i++) begin
         if (reset) begin
            regs_reg[i] <= '0;
         end else if (wr_dec[i]) begin
            regs_reg[i] <= din;
         end
      end
   end

   assign rd_data = regs_reg[rd_sel];

   // Operands come from the pre-edge register values, so a same-edge load
   // never leaks into the operation.
   assign op_a   = acc_mode ? result_reg : regs_reg[sel_a];
   assign op_b   = regs_reg[sel_b];
   assign alu_op = alu_op_t'(op);

   assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
   assign diff_ext = {1'b0, op_a} - {1'b0, op_b};

   always_comb begin
      result_next   = '0;
      carry_next    = 1'b0;
      overflow_next = 1'b0;
      unique case (alu_op)
         OP_ADD: begin
            result_next   = sum_ext[WIDTH-1:0];
            carry_next    = sum_ext[WIDTH];
            overflow_next = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                            (sum_ext[WIDTH-1] != op_a[WIDTH-1]);
         end
         OP_SUB: begin
            // The extended MSB of the difference is the unsigned borrow.
            result_next   = diff_ext[WIDTH-1:0];
            carry_next    = diff_ext[WIDTH];
            overflow_next = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                            (diff_ext[WIDTH-1] != op_a[WIDTH-1]);
         end
         OP_AND: result_next = op_a & op_b;
         OP_XOR: result_next = op_a ^ op_b;
         default: result_next = '0;
      endcase
      zero_next = (result_next == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result_reg   <= '0;
         carry_reg    <= 1'b0;
         overflow_reg <= 1'b0;
         zero_reg     <= 1'b1;
         valid_reg    <= 1'b0;
      end else begin
         valid_reg <= exec_en;
         if (exec_en) begin
            result_reg   <= result_next;
            carry_reg    <= carry_next;
            overflow_reg <= overflow_next;
            zero_reg     <= zero_next;
         end
      end
   end

   assign result   = result_reg;
   assign carry    = carry_reg;
   assign overflow = overflow_reg;
   assign zero     = zero_reg;
   assign valid    = valid_reg;

endmodule
